// File: rtl/response_packet_builder.sv
`default_nettype none
// ============================================================================
// Module   : response_packet_builder
// Purpose  : Builds Ethernet/IPv4/UDP/app-header reply packets from latched
//            request metadata plus a payload stream. MAC, IP and port fields
//            are swapped so the reply returns to the requester. The 50-byte
//            header spans two 256-bit beats, so the payload is realigned by
//            18 bytes through a residue register.
//            Optional feature: define RESPONSE_BUILDER_IP_CSUM_EN to fill in
//            the IPv4 header checksum (otherwise the field is 0x0000).
// Revision : 1.0 - initial release
// ============================================================================
module response_packet_builder #(
    parameter int TDATA_WIDTH = 256,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                     axis_aclk,
    input  logic                     reset,
    input  logic [47:0]              src_mac_addr_in,
    input  logic [47:0]              dest_mac_addr_in,
    input  logic [31:0]              src_ip_addr_in,
    input  logic [31:0]              dest_ip_addr_in,
    input  logic [15:0]              src_port_in,
    input  logic [15:0]              dest_port_in,
    input  logic [63:0]              app_header_in,
    input  logic [15:0]              body_len_in,
    input  logic [TUSER_WIDTH-1:0]   tuser_in,
    input  logic                     metadata_valid,
    output logic                     metadata_ready,
    input  logic [TDATA_WIDTH-1:0]   body_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0] body_axis_tkeep,
    input  logic                     body_axis_tvalid,
    input  logic                     body_axis_tlast,
    output logic                     body_axis_tready,
    output logic [TDATA_WIDTH-1:0]   packet_out_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] packet_out_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]   packet_out_axis_tuser,
    output logic                     packet_out_axis_tvalid,
    output logic                     packet_out_axis_tlast,
    input  logic                     packet_out_axis_tready
);

    localparam int TKEEP_WIDTH     = TDATA_WIDTH / 8;
    localparam int CNT_W           = $clog2(TKEEP_WIDTH + 1);
    localparam int HDR_TAIL_BYTES  = 18;   // header bytes 32..49 carried in beat 1
    localparam int BODY_LEAD_BYTES = 14;   // body bytes that fit beside them
    localparam int RES_W           = 8 * HDR_TAIL_BYTES;
    localparam int LEAD_W          = 8 * BODY_LEAD_BYTES;
    localparam logic [CNT_W-1:0]       LEAD_CNT = CNT_W'(BODY_LEAD_BYTES);
    localparam logic [CNT_W-1:0]       RES_CNT  = CNT_W'(HDR_TAIL_BYTES);
    localparam logic [CNT_W-1:0]       FULL_CNT = CNT_W'(TKEEP_WIDTH);
    localparam logic [TKEEP_WIDTH:0]   KEEP_ONE = (TKEEP_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_BODY = 3'd3,
        S_TAIL = 3'd4
    } state_t;

    state_t                 state_q;
    logic [47:0]            src_mac_q;
    logic [47:0]            dst_mac_q;
    logic [31:0]            src_ip_q;
    logic [31:0]            dst_ip_q;
    logic [15:0]            src_port_q;
    logic [15:0]            dst_port_q;
    logic [15:0]            body_len_q;
    logic [63:0]            app_hdr_q;
    logic [TUSER_WIDTH-1:0] tuser_q;
    logic [RES_W-1:0]       residue_q;
    logic [CNT_W-1:0]       tail_cnt_q;

    logic [15:0]            ip_csum;
    logic [15:0]            total_len;
    logic [15:0]            udp_len;
    logic [TDATA_WIDTH+RES_W-1:0] hdr;
    logic [CNT_W-1:0]       body_cnt;
    logic [CNT_W-1:0]       keep_cnt;
    logic [TKEEP_WIDTH:0]   keep_mask;

    assign metadata_ready = (state_q == S_IDLE);

`ifdef RESPONSE_BUILDER_IP_CSUM_EN
    logic [15:0] csum_len;
    logic [19:0] csum_sum;
    logic [16:0] csum_f1;
    logic [15:0] csum_f2;
    logic [15:0] csum_d;
    logic [15:0] csum_q;

    // One's-complement sum of the reply's ten IPv4 header words, taken from the request inputs.
    always_comb begin
        csum_len = body_len_in + 16'd36;
        csum_sum = 20'h04500 + {4'd0, csum_len} + 20'h04011
                 + {4'd0, dest_ip_addr_in[7:0],   dest_ip_addr_in[15:8]}
                 + {4'd0, dest_ip_addr_in[23:16], dest_ip_addr_in[31:24]}
                 + {4'd0, src_ip_addr_in[7:0],    src_ip_addr_in[15:8]}
                 + {4'd0, src_ip_addr_in[23:16],  src_ip_addr_in[31:24]};
        csum_f1  = {1'b0, csum_sum[15:0]} + {13'd0, csum_sum[19:16]};
        csum_f2  = csum_f1[15:0] + {15'd0, csum_f1[16]};
        csum_d   = ~csum_f2;
    end

    // Capture the checksum together with the metadata so it is ready for beat 0.
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            csum_q <= '0;
        end else if (state_q == S_IDLE && metadata_valid) begin
            csum_q <= csum_d;
        end
    end

    assign ip_csum = csum_q;
`else
    assign ip_csum = 16'h0000;
`endif

    assign total_len = body_len_q + 16'd36;
    assign udp_len   = body_len_q + 16'd16;

    // 50-byte reply header, byte n at bits [8n+7:8n]; lengths and checksum big-endian.
    assign hdr = {app_hdr_q, 16'h0000, udp_len[7:0], udp_len[15:8],
                  src_port_q, dst_port_q, src_ip_q, dst_ip_q,
                  ip_csum[7:0], ip_csum[15:8], 8'h11, 8'h40, 16'h0000, 16'h0000,
                  total_len[7:0], total_len[15:8], 8'h00, 8'h45,
                  8'h00, 8'h08, dst_mac_q, src_mac_q};

    // Byte count of the current body beat (tkeep is contiguous from bit 0).
    always_comb begin
        body_cnt = '0;
        for (int i = 0; i < TKEEP_WIDTH; i++) begin
            body_cnt = body_cnt + CNT_W'(body_axis_tkeep[i]);
        end
    end

    // Output decode: header beats from latched fields, body beats shifted by 18 bytes.
    always_comb begin
        packet_out_axis_tvalid = 1'b0;
        packet_out_axis_tdata  = '0;
        packet_out_axis_tuser  = '0;
        packet_out_axis_tlast  = 1'b0;
        packet_out_axis_tkeep  = '0;
        body_axis_tready       = 1'b0;
        keep_cnt               = FULL_CNT;
        keep_mask              = '0;
        case (state_q)
            S_HDR0: begin
                packet_out_axis_tvalid = 1'b1;
                packet_out_axis_tdata  = hdr[TDATA_WIDTH-1:0];
                packet_out_axis_tuser  = tuser_q;
                packet_out_axis_tkeep  = '1;
            end
            S_HDR1, S_BODY: begin
                packet_out_axis_tvalid = body_axis_tvalid;
                body_axis_tready       = packet_out_axis_tready;
                packet_out_axis_tdata  = {body_axis_tdata[LEAD_W-1:0],
                                          (state_q == S_HDR1) ? hdr[TDATA_WIDTH+RES_W-1:TDATA_WIDTH]
                                                              : residue_q};
                if (body_axis_tlast && body_cnt <= LEAD_CNT) begin
                    packet_out_axis_tlast = 1'b1;
                    keep_cnt              = body_cnt + RES_CNT;
                end
                keep_mask             = (KEEP_ONE << keep_cnt) - KEEP_ONE;
                packet_out_axis_tkeep = keep_mask[TKEEP_WIDTH-1:0];
            end
            S_TAIL: begin
                packet_out_axis_tvalid = 1'b1;
                packet_out_axis_tdata  = {{LEAD_W{1'b0}}, residue_q};
                packet_out_axis_tlast  = 1'b1;
                keep_cnt               = tail_cnt_q;
                keep_mask              = (KEEP_ONE << keep_cnt) - KEEP_ONE;
                packet_out_axis_tkeep  = keep_mask[TKEEP_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    // Packet sequencing, metadata capture and residue tracking.
    always_ff @(posedge axis_aclk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_mac_q  <= '0;
            dst_mac_q  <= '0;
            src_ip_q   <= '0;
            dst_ip_q   <= '0;
            src_port_q <= '0;
            dst_port_q <= '0;
            body_len_q <= '0;
            app_hdr_q  <= '0;
            tuser_q    <= '0;
            residue_q  <= '0;
            tail_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (metadata_valid) begin
                        src_mac_q  <= src_mac_addr_in;
                        dst_mac_q  <= dest_mac_addr_in;
                        src_ip_q   <= src_ip_addr_in;
                        dst_ip_q   <= dest_ip_addr_in;
                        src_port_q <= src_port_in;
                        dst_port_q <= dest_port_in;
                        body_len_q <= body_len_in;
                        app_hdr_q  <= app_header_in;
                        tuser_q    <= tuser_in;
                        state_q    <= S_HDR0;
                    end
                end
                S_HDR0: begin
                    if (packet_out_axis_tready) begin
                        state_q <= S_HDR1;
                    end
                end
                S_HDR1, S_BODY: begin
                    if (body_axis_tvalid && packet_out_axis_tready) begin
                        residue_q <= body_axis_tdata[TDATA_WIDTH-1:LEAD_W];
                        if (!body_axis_tlast) begin
                            state_q <= S_BODY;
                        end else if (body_cnt <= LEAD_CNT) begin
                            state_q <= S_IDLE;
                        end else begin
                            tail_cnt_q <= body_cnt - LEAD_CNT;
                            state_q    <= S_TAIL;
                        end
                    end
                end
                S_TAIL: begin
                    if (packet_out_axis_tready) begin
                        residue_q <= '0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_response_packet_builder.sv
`default_nettype none
// ============================================================================
// Module   : tb_response_packet_builder
// Purpose  : Randomized scoreboard bench for response_packet_builder. Each
//            packet is modelled as a flat byte string (header + payload) and
//            chopped into 32-byte beats that a monitor compares against.
// Revision : 1.0 - initial release
// ============================================================================
module tb_response_packet_builder;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic [127:0] user;
        logic         last;
    } beat_t;

    logic         axis_aclk = 1'b0;
    logic         reset     = 1'b1;
    logic [47:0]  src_mac_addr_in = '0, dest_mac_addr_in = '0;
    logic [31:0]  src_ip_addr_in = '0, dest_ip_addr_in = '0;
    logic [15:0]  src_port_in = '0, dest_port_in = '0;
    logic [63:0]  app_header_in = '0;
    logic [15:0]  body_len_in = '0;
    logic [127:0] tuser_in = '0;
    logic         metadata_valid = 1'b0;
    logic         metadata_ready;
    logic [255:0] body_axis_tdata = '0;
    logic [31:0]  body_axis_tkeep = '0;
    logic         body_axis_tvalid = 1'b0;
    logic         body_axis_tlast = 1'b0;
    logic         body_axis_tready;
    logic [255:0] packet_out_axis_tdata;
    logic [31:0]  packet_out_axis_tkeep;
    logic [127:0] packet_out_axis_tuser;
    logic         packet_out_axis_tvalid;
    logic         packet_out_axis_tlast;
    logic         packet_out_axis_tready = 1'b1;

    response_packet_builder #(.TDATA_WIDTH(256), .TUSER_WIDTH(128)) dut (
        .axis_aclk              (axis_aclk),
        .reset                  (reset),
        .src_mac_addr_in        (src_mac_addr_in),
        .dest_mac_addr_in       (dest_mac_addr_in),
        .src_ip_addr_in         (src_ip_addr_in),
        .dest_ip_addr_in        (dest_ip_addr_in),
        .src_port_in            (src_port_in),
        .dest_port_in           (dest_port_in),
        .app_header_in          (app_header_in),
        .body_len_in            (body_len_in),
        .tuser_in               (tuser_in),
        .metadata_valid         (metadata_valid),
        .metadata_ready         (metadata_ready),
        .body_axis_tdata        (body_axis_tdata),
        .body_axis_tkeep        (body_axis_tkeep),
        .body_axis_tvalid       (body_axis_tvalid),
        .body_axis_tlast        (body_axis_tlast),
        .body_axis_tready       (body_axis_tready),
        .packet_out_axis_tdata  (packet_out_axis_tdata),
        .packet_out_axis_tkeep  (packet_out_axis_tkeep),
        .packet_out_axis_tuser  (packet_out_axis_tuser),
        .packet_out_axis_tvalid (packet_out_axis_tvalid),
        .packet_out_axis_tlast  (packet_out_axis_tlast),
        .packet_out_axis_tready (packet_out_axis_tready)
    );

    always #5 axis_aclk = ~axis_aclk;

    int    n_cmp = 0;
    int    n_err = 0;
    bit    stall_en = 1'b0;
    beat_t exp_q[$];

    // Fields of the packet currently being issued.
    logic [47:0]  p_smac, p_dmac;
    logic [31:0]  p_sip, p_dip;
    logic [15:0]  p_sport, p_dport, p_blen;
    logic [63:0]  p_app;
    logic [127:0] p_user;
    logic [7:0]   p_pay[$];

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic timeout(input string what);
        n_cmp++;
        n_err++;
        $display("FAIL timeout_%s: bound expired waiting on DUT", what);
        finish_run();
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic rand_fields();
        p_smac  = {16'($urandom()), $urandom()};
        p_dmac  = {16'($urandom()), $urandom()};
        p_sip   = $urandom();
        p_dip   = $urandom();
        p_sport = 16'($urandom());
        p_dport = 16'($urandom());
        p_app   = {$urandom(), $urandom()};
        p_user  = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    // Reference model: build the reply as a byte string, then cut it into beats.
    task automatic model_push(input int limit);
        logic [7:0]  pk[$];
        logic [15:0] tl, ul, cs;
        logic [31:0] s;
        beat_t       bt;
        tl = p_blen + 16'd36;
        ul = p_blen + 16'd16;
        for (int i = 0; i < 6; i++) pk.push_back(p_smac[8*i +: 8]);
        for (int i = 0; i < 6; i++) pk.push_back(p_dmac[8*i +: 8]);
        pk.push_back(8'h08); pk.push_back(8'h00);
        pk.push_back(8'h45); pk.push_back(8'h00);
        pk.push_back(tl[15:8]); pk.push_back(tl[7:0]);
        for (int i = 0; i < 4; i++) pk.push_back(8'h00);
        pk.push_back(8'h40); pk.push_back(8'h11);
        pk.push_back(8'h00); pk.push_back(8'h00);
        for (int i = 0; i < 4; i++) pk.push_back(p_dip[8*i +: 8]);
        for (int i = 0; i < 4; i++) pk.push_back(p_sip[8*i +: 8]);
        for (int i = 0; i < 2; i++) pk.push_back(p_dport[8*i +: 8]);
        for (int i = 0; i < 2; i++) pk.push_back(p_sport[8*i +: 8]);
        pk.push_back(ul[15:8]); pk.push_back(ul[7:0]);
        pk.push_back(8'h00); pk.push_back(8'h00);
        for (int i = 0; i < 8; i++) pk.push_back(p_app[8*i +: 8]);
`ifdef RESPONSE_BUILDER_IP_CSUM_EN
        s = 0;
        for (int w = 0; w < 10; w++) s = s + {16'd0, pk[14+2*w], pk[15+2*w]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        pk[24] = cs[15:8];
        pk[25] = cs[7:0];
`else
        s  = 0;
        cs = 16'h0000;
`endif
        foreach (p_pay[i]) pk.push_back(p_pay[i]);
        for (int b = 0; b * 32 < pk.size(); b++) begin
            bt = '0;
            for (int j = 0; j < 32; j++) begin
                if (b * 32 + j < pk.size()) begin
                    bt.data[8*j +: 8] = pk[b*32+j];
                    bt.keep[j]        = 1'b1;
                end
            end
            bt.user = (b == 0) ? p_user : 128'd0;
            bt.last = ((b + 1) * 32 >= pk.size());
            if (b < limit) exp_q.push_back(bt);
        end
    endtask

    // Issue one packet: metadata, then body beats with random idle gaps.
    // With partial set, only body beat 0 is sent and reset is pulsed mid-packet.
    task automatic send_packet(input int nbody, input bit partial);
        int           nb, cyc, cnt;
        logic [255:0] d;
        logic [31:0]  k;
        p_pay.delete();
        for (int i = 0; i < nbody; i++) p_pay.push_back(8'($urandom_range(0, 255)));
        model_push(partial ? 2 : 1000);
        @(posedge axis_aclk); #1;
        src_mac_addr_in  = p_smac;  dest_mac_addr_in = p_dmac;
        src_ip_addr_in   = p_sip;   dest_ip_addr_in  = p_dip;
        src_port_in      = p_sport; dest_port_in     = p_dport;
        app_header_in    = p_app;   body_len_in      = p_blen;
        tuser_in         = p_user;  metadata_valid   = 1'b1;
        cyc = 0;
        @(negedge axis_aclk);
        while (!metadata_ready) begin
            cyc++;
            if (cyc > 400) timeout("metadata_accept");
            @(negedge axis_aclk);
        end
        @(posedge axis_aclk); #1;
        metadata_valid = 1'b0;
        @(negedge axis_aclk);
        check("beat0_valid_next_cycle", {255'd0, packet_out_axis_tvalid}, 256'd1);
        check("hdr0_body_tready_low", {255'd0, body_axis_tready}, 256'd0);
        @(posedge axis_aclk); #1;
        nb = (nbody + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            if (partial && b == 1) break;
            repeat ($urandom_range(0, 2)) begin
                @(posedge axis_aclk); #1;
            end
            for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom();
            cnt = (nbody - 32 * b > 32) ? 32 : nbody - 32 * b;
            for (int j = 0; j < cnt; j++) d[8*j +: 8] = p_pay[32*b+j];
            k = (cnt == 32) ? 32'hFFFF_FFFF : ((32'd1 << cnt) - 32'd1);
            body_axis_tdata  = d;
            body_axis_tkeep  = k;
            body_axis_tlast  = (b == nb - 1);
            body_axis_tvalid = 1'b1;
            cyc = 0;
            @(negedge axis_aclk);
            while (!body_axis_tready) begin
                cyc++;
                if (cyc > 400) timeout("body_accept");
                @(negedge axis_aclk);
            end
            @(posedge axis_aclk); #1;
            body_axis_tvalid = 1'b0;
            body_axis_tlast  = 1'b0;
        end
        if (partial) begin
            reset = 1'b1;
            @(posedge axis_aclk);
            @(negedge axis_aclk);
            check("reset_midpkt_tvalid", {255'd0, packet_out_axis_tvalid}, 256'd0);
            check("reset_midpkt_meta_ready", {255'd0, metadata_ready}, 256'd1);
            @(posedge axis_aclk); #1;
            reset = 1'b0;
        end
    endtask

    // Random output back-pressure.
    initial begin
        forever begin
            @(posedge axis_aclk); #1;
            packet_out_axis_tready = stall_en ? ($urandom_range(0, 99) < 65) : 1'b1;
        end
    end

    // Monitor: pops expected beats on every output handshake, checks stability under stall.
    initial begin
        beat_t        e;
        logic [255:0] m;
        logic [255:0] h_data;
        logic [31:0]  h_keep;
        logic         h_last;
        bit           stalled;
        stalled = 1'b0;
        h_data  = '0;
        h_keep  = '0;
        h_last  = 1'b0;
        forever begin
            @(negedge axis_aclk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled && packet_out_axis_tvalid) begin
                    n_cmp++;
                    if (packet_out_axis_tdata !== h_data || packet_out_axis_tkeep !== h_keep ||
                        packet_out_axis_tlast !== h_last) begin
                        n_err++;
                        $display("FAIL stall_stable: got keep=%h last=%b data=%h want keep=%h last=%b data=%h",
                                 packet_out_axis_tkeep, packet_out_axis_tlast, packet_out_axis_tdata,
                                 h_keep, h_last, h_data);
                    end
                end
                if (packet_out_axis_tvalid && packet_out_axis_tready) begin
                    stalled = 1'b0;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got data=%h with no beat expected",
                                 packet_out_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        m = '0;
                        for (int j = 0; j < 32; j++) if (e.keep[j]) m[8*j +: 8] = 8'hFF;
                        if (packet_out_axis_tkeep !== e.keep || packet_out_axis_tuser !== e.user ||
                            packet_out_axis_tlast !== e.last ||
                            (packet_out_axis_tdata & m) !== (e.data & m)) begin
                            n_err++;
                            $display("FAIL beat: got keep=%h last=%b user=%h data=%h want keep=%h last=%b user=%h data=%h",
                                     packet_out_axis_tkeep, packet_out_axis_tlast, packet_out_axis_tuser,
                                     packet_out_axis_tdata & m, e.keep, e.last, e.user, e.data & m);
                        end
                    end
                end else if (packet_out_axis_tvalid) begin
                    stalled = 1'b1;
                    h_data  = packet_out_axis_tdata;
                    h_keep  = packet_out_axis_tkeep;
                    h_last  = packet_out_axis_tlast;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int bnd[9];
        int n, cyc;
        bnd = '{1, 14, 15, 18, 32, 33, 46, 47, 64};
        reset = 1'b1;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        check("rst_tvalid", {255'd0, packet_out_axis_tvalid}, 256'd0);
        check("rst_tlast", {255'd0, packet_out_axis_tlast}, 256'd0);
        check("rst_tkeep", {224'd0, packet_out_axis_tkeep}, 256'd0);
        check("rst_tuser", {128'd0, packet_out_axis_tuser}, 256'd0);
        check("rst_tdata", packet_out_axis_tdata, 256'd0);
        check("rst_meta_ready", {255'd0, metadata_ready}, 256'd1);
        check("rst_body_tready", {255'd0, body_axis_tready}, 256'd0);
        @(posedge axis_aclk); #1;
        reset = 1'b0;

        // Single short beat; distinctive MACs and ports for the swap.
        rand_fields();
        p_smac  = 48'h665544332211;
        p_dmac  = 48'hCCBBAA998877;
        p_sport = 16'h3412;
        p_dport = 16'h7856;
        p_blen  = 16'd10;
        send_packet(10, 1'b0);

        // Two body beats ending in a TAIL beat.
        rand_fields(); p_blen = 16'd52; send_packet(52, 1'b0);

        // Last-beat keep-count boundaries around 14 and 32.
        foreach (bnd[i]) begin
            rand_fields();
            p_blen = 16'(bnd[i]);
            send_packet(bnd[i], 1'b0);
        end

        // Length fields wrap modulo 2^16.
        rand_fields(); p_blen = 16'hFFF0; send_packet(5, 1'b0);

        // Checksum reference case: 10.0.0.1 <-> 10.0.0.2, body_len 0.
        rand_fields();
        p_sip  = 32'h0100000A;
        p_dip  = 32'h0200000A;
        p_blen = 16'd0;
        send_packet(4, 1'b0);

        // Back-pressure: 5-beat payloads, then random sizes.
        stall_en = 1'b1;
        repeat (4) begin
            rand_fields(); p_blen = 16'd160; send_packet(160, 1'b0);
        end
        repeat (25) begin
            n = $urandom_range(1, 200);
            rand_fields(); p_blen = 16'(n); send_packet(n, 1'b0);
        end

        // Reset in the middle of a packet, then a normal packet.
        rand_fields(); p_blen = 16'd80; send_packet(80, 1'b1);
        rand_fields(); p_blen = 16'd40; send_packet(40, 1'b0);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 3000) begin
            @(negedge axis_aclk);
            cyc++;
        end
        check("all_beats_emitted", 256'(exp_q.size()), 256'd0);
        repeat (3) @(negedge axis_aclk);
        check("end_idle_meta_ready", {255'd0, metadata_ready}, 256'd1);
        check("end_idle_tvalid", {255'd0, packet_out_axis_tvalid}, 256'd0);
        finish_run();
    end

endmodule
`default_nettype wire
